// File: rtl/flo_scan_if.sv
// flo_scan_if: load and result handshake bundle for flo_scan.
//   master: drives ld_valid/ld_vec (and ld_msb when enabled) and o_ready;
//           observes ld_ready and the o_* result beat.
//   slave : the scanner side, the mirror of master.
// Optional: FLO_SCAN_MSB_EN adds ld_msb (scan direction select).
interface flo_scan_if #(
    parameter int unsigned WIDTH = 64
);
    localparam int unsigned IDXW = $clog2(WIDTH + 1);

    logic             ld_valid;
    logic             ld_ready;
    logic [WIDTH-1:0] ld_vec;
`ifdef FLO_SCAN_MSB_EN
    logic             ld_msb;
`endif
    logic             o_valid;
    logic             o_ready;
    logic [IDXW-1:0]  o_idx;
    logic             o_none;
    logic             o_last;

    modport master (
`ifdef FLO_SCAN_MSB_EN
        output ld_msb,
`endif
        output ld_valid, ld_vec, o_ready,
        input  ld_ready, o_valid, o_idx, o_none, o_last
    );

    modport slave (
`ifdef FLO_SCAN_MSB_EN
        input  ld_msb,
`endif
        input  ld_valid, ld_vec, o_ready,
        output ld_ready, o_valid, o_idx, o_none, o_last
    );
endinterface

// File: rtl/flo_scan.sv
// flo_scan: sequential set-bit walker. Loads a WIDTH-bit vector, then emits
// the index of every set bit, lowest first, one per output handshake.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   abort      : synchronous flush of the current scan (highest priority)
//   cnt        : beats accepted since the last load
//   busy       : scan in progress
//   bus        : flo_scan_if.slave (ld_* load port, o_* result port)
// Optional: define FLO_SCAN_MSB_EN to add ld_msb (1 = highest-first scan).
module flo_scan #(
    parameter  int unsigned WIDTH = 64,
    localparam int unsigned IDXW  = $clog2(WIDTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            abort,
    output logic [IDXW-1:0] cnt,
    output logic            busy,
    flo_scan_if.slave       bus
);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] mask_clr;
    logic             none_q;
    logic [IDXW-1:0]  pick;
    logic             last_c;
    logic             beat_fire;
    logic             ld_fire;
`ifdef FLO_SCAN_MSB_EN
    logic             msb_q;
`endif

    // Select the bit to report and the mask with that bit removed
    always_comb begin
        pick = '1;
`ifdef FLO_SCAN_MSB_EN
        if (msb_q) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (mask[i]) pick = IDXW'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (mask[i]) pick = IDXW'(i);
            end
        end
`else
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask[i]) pick = IDXW'(i);
        end
`endif
        mask_clr = mask;
        for (int i = 0; i < WIDTH; i++) begin
            if (IDXW'(i) == pick) mask_clr[i] = 1'b0;
        end
        // At most one bit left means this is the final beat, whatever the direction
        last_c = none_q | ((mask & (mask - WIDTH'(1))) == '0);
    end

    // A beat presented while abort is high is dropped
    assign beat_fire = (state == SCAN) & bus.o_ready & ~abort;
    assign ld_fire   = bus.ld_valid & bus.ld_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (!abort && ld_fire) state_nxt = SCAN;
            SCAN: begin
                if (abort)                   state_nxt = IDLE;
                else if (beat_fire && last_c) state_nxt = ld_fire ? SCAN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic; ld_ready in SCAN follows o_ready for back-to-back loads
    always_comb begin
        bus.o_valid  = 1'b0;
        bus.o_idx    = '1;
        bus.o_none   = 1'b0;
        bus.o_last   = 1'b0;
        bus.ld_ready = 1'b0;
        busy         = 1'b0;
        unique case (state)
            IDLE: bus.ld_ready = ~abort;
            SCAN: begin
                bus.o_valid  = 1'b1;
                bus.o_idx    = pick;
                bus.o_none   = none_q;
                bus.o_last   = last_c;
                bus.ld_ready = bus.o_ready & last_c & ~abort;
                busy         = 1'b1;
            end
            default: ;
        endcase
    end

    // Scan datapath: abort beats load beats consume
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask   <= '0;
            cnt    <= '0;
            none_q <= 1'b0;
`ifdef FLO_SCAN_MSB_EN
            msb_q  <= 1'b0;
`endif
        end else if (abort) begin
            mask <= '0;
        end else if (ld_fire) begin
            mask   <= bus.ld_vec;
            cnt    <= '0;
            none_q <= (bus.ld_vec == '0);
`ifdef FLO_SCAN_MSB_EN
            msb_q  <= bus.ld_msb;
`endif
        end else if (beat_fire) begin
            mask <= mask_clr;
            cnt  <= cnt + IDXW'(1);
        end
    end

endmodule

// File: tb/tb_flo_scan.sv
// tb_flo_scan: directed-vector bench for flo_scan (WIDTH = 64).
module tb_flo_scan;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned IDXW  = 7;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            abort;
    logic [IDXW-1:0] cnt;
    logic            busy;

    int n_vec = 0;
    int n_err = 0;

    flo_scan_if #(.WIDTH(WIDTH)) bus ();

    flo_scan #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .abort (abort),
        .cnt   (cnt),
        .busy  (busy),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input int idx, input bit last, input bit none, input int c);
        chk({tag, ".valid"}, 64'(bus.o_valid), 64'd1);
        chk({tag, ".idx"},   64'(bus.o_idx),   64'(idx));
        chk({tag, ".last"},  64'(bus.o_last),  64'(last));
        chk({tag, ".none"},  64'(bus.o_none),  64'(none));
        chk({tag, ".cnt"},   64'(cnt),         64'(c));
    endtask

    task automatic idle_chk(input string tag, input int c);
        chk({tag, ".valid"}, 64'(bus.o_valid), 64'd0);
        chk({tag, ".busy"},  64'(busy),        64'd0);
        chk({tag, ".cnt"},   64'(cnt),         64'(c));
    endtask

    // Present a load in IDLE and step past its handshake
    task automatic do_load(input string tag, input logic [63:0] v, input bit msb);
        bus.ld_valid = 1'b1;
        bus.ld_vec   = v;
`ifdef FLO_SCAN_MSB_EN
        bus.ld_msb   = msb;
`else
        if (msb) $display("note: ld_msb ignored in this build");
`endif
        #1;
        chk({tag, ".ld_ready"}, 64'(bus.ld_ready), 64'd1);
        tick();
        bus.ld_valid = 1'b0;
`ifdef FLO_SCAN_MSB_EN
        bus.ld_msb   = 1'b0;
`endif
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        abort        = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_vec   = '0;
        bus.o_ready  = 1'b0;
`ifdef FLO_SCAN_MSB_EN
        bus.ld_msb   = 1'b0;
`endif
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("rst.valid",    64'(bus.o_valid),  64'd0);
        chk("rst.ld_ready", 64'(bus.ld_ready), 64'd1);
        chk("rst.busy",     64'(busy),         64'd0);
        chk("rst.cnt",      64'(cnt),          64'd0);
        chk("rst.idx",      64'(bus.o_idx),    64'd127);
        chk("rst.last",     64'(bus.o_last),   64'd0);
        chk("rst.none",     64'(bus.o_none),   64'd0);

        // Three beats: 0, 4, 63
        bus.o_ready = 1'b1;
        do_load("t1.ld", 64'h8000_0000_0000_0011, 1'b0);
        beat("t1.b0", 0, 1'b0, 1'b0, 0);
        tick();
        beat("t1.b1", 4, 1'b0, 1'b0, 1);
        tick();
        beat("t1.b2", 63, 1'b1, 1'b0, 2);
        tick();
        idle_chk("t1.end", 3);

        // Empty vector: single none beat
        do_load("t2.ld", 64'h0, 1'b0);
        beat("t2.b0", 127, 1'b1, 1'b1, 0);
        tick();
        idle_chk("t2.end", 1);
        chk("t2.none_idle", 64'(bus.o_none), 64'd0);

        // Backpressure holds the beat
        bus.o_ready = 1'b0;
        do_load("t3.ld", 64'h6, 1'b0);
        beat("t3.h0", 1, 1'b0, 1'b0, 0);
        tick();
        beat("t3.h1", 1, 1'b0, 1'b0, 0);
        tick();
        beat("t3.h2", 1, 1'b0, 1'b0, 0);
        bus.o_ready = 1'b1;
        #1;
        chk("t3.ld_ready_mid", 64'(bus.ld_ready), 64'd0);
        tick();
        beat("t3.b1", 2, 1'b1, 1'b0, 1);
        tick();
        idle_chk("t3.end", 2);

        // Abort with a competing load
        do_load("t4.ld", 64'hF0, 1'b0);
        beat("t4.b0", 4, 1'b0, 1'b0, 0);
        tick();
        beat("t4.b1", 5, 1'b0, 1'b0, 1);
        abort        = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_vec   = 64'h3;
        #1;
        chk("t4.ld_ready_abort", 64'(bus.ld_ready), 64'd0);
        tick();
        abort        = 1'b0;
        bus.ld_valid = 1'b0;
        #1;
        idle_chk("t4.post", 1);
        chk("t4.ld_ready", 64'(bus.ld_ready), 64'd1);
        tick();
        chk("t4.refused", 64'(bus.o_valid), 64'd0);

        // Back-to-back load on the final beat
        do_load("t5.ld", 64'h1, 1'b0);
        beat("t5.b0", 0, 1'b1, 1'b0, 0);
        bus.ld_valid = 1'b1;
        bus.ld_vec   = 64'h2;
        #1;
        chk("t5.ld_ready_b2b", 64'(bus.ld_ready), 64'd1);
        tick();
        bus.ld_valid = 1'b0;
        beat("t5.b1", 1, 1'b1, 1'b0, 0);
        tick();
        idle_chk("t5.end", 1);

        // Top bit alone
        do_load("t6.ld", 64'h8000_0000_0000_0000, 1'b0);
        beat("t6.b0", 63, 1'b1, 1'b0, 0);
        tick();
        idle_chk("t6.end", 1);

        // Reset mid-scan
        do_load("t7.ld", 64'hF, 1'b0);
        beat("t7.b0", 0, 1'b0, 1'b0, 0);
        tick();
        rst_n = 1'b0;
        #1;
        idle_chk("t7.rst", 0);
        chk("t7.idx", 64'(bus.o_idx), 64'd127);
        tick();
        rst_n = 1'b1;
        tick();
        idle_chk("t7.after", 0);

`ifdef FLO_SCAN_MSB_EN
        // Highest-first scan
        do_load("t8.ld", 64'h11, 1'b1);
        beat("t8.b0", 4, 1'b0, 1'b0, 0);
        tick();
        beat("t8.b1", 0, 1'b1, 1'b0, 1);
        tick();
        idle_chk("t8.end", 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/flo_scan.md
Name: flo_scan

Overview:
- Parametrised, sequential successor to the team's fixed 6-bit find-lowest-one encoder.
- Accepts a WIDTH-bit vector over a valid/ready load port.
- Emits the index of every set bit in turn, lowest first, one per handshake, on a valid/ready output port.
- Used by schedulers and free-list allocators that must walk all set bits of a request/free mask, not only the first.

Parameters:
- WIDTH, 64, bit width of the scanned vector (>= 2).
- IDXW, $clog2(WIDTH+1), index output width (localparam, derived). Wide enough that the all-ones "none" code never collides with a valid index.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ld_valid  input  1  load request.
- ld_ready  output  1  block can accept a load this cycle.
- ld_vec  input  WIDTH  vector to scan; sampled when ld_valid & ld_ready.
- abort  input  1  synchronous flush of the current scan.
- o_valid  output  1  o_idx/o_none/o_last valid.
- o_ready  input  1  consumer accepts the current beat.
- o_idx  output  IDXW  index of the current lowest remaining set bit; all ones when o_none.
- o_none  output  1  loaded vector was all zeros.
- o_last  output  1  current beat is the final beat of this vector.
- cnt  output  IDXW  beats accepted since the last load.
- busy  output  1  scan in progress (state SCAN).

Behaviour:
- Reset: state IDLE, mask 0, cnt 0. Outputs: o_valid 0, o_idx all ones, o_none 0, o_last 0, busy 0, ld_ready 1.
- State IDLE:
  - ld_ready = ~abort.
  - On ld_valid & ld_ready: mask <= ld_vec, cnt <= 0, none_q <= (ld_vec == 0), go SCAN.
- State SCAN:
  - o_valid = 1, busy = 1.
  - o_idx = position of the lowest set bit of mask, combinational from registered mask, i.e. from registers only.
  - o_last = none_q | ((mask & (mask-1)) == 0).
  - o_none = none_q; when none_q, o_idx is all ones.
- Handshake: beat transfers when o_valid & o_ready.
  - Clears the lowest set bit of mask and increments cnt.
  - If o_last, go IDLE.
- Latency: first beat valid on the cycle after the load handshake. One beat per cycle thereafter while o_ready = 1.
- Backpressure: while o_valid & ~o_ready, o_idx/o_last/o_none/cnt hold stable.
- Back-to-back loads:
  - ld_ready is also 1 in SCAN when o_valid & o_ready & o_last & ~abort. This path is combinational from o_ready.
  - A load in that cycle goes straight to SCAN with the new vector; no idle bubble.
- Empty vector: exactly one beat with o_none = 1, o_last = 1, o_idx all ones. cnt becomes 1 after it transfers.
- Abort:
  - Highest priority: next state IDLE, mask <= 0. cnt holds its value.
  - Any beat presented in the abort cycle is considered dropped, even if o_ready = 1.
  - A load in the same cycle is refused, since ld_ready = 0.
- Bit WIDTH-1 set alone: o_idx = WIDTH-1, o_last = 1. No wrap-around; the scan never revisits bits.
- Reset asserted mid-scan: immediate return to the reset values above; no beat completes.

Optional Feature:
- Macro FLO_SCAN_MSB_EN.
- When defined:
  - Adds input ld_msb (1 bit), sampled with ld_vec.
  - ld_msb = 1 scans highest-first: o_idx is the highest remaining set bit, and each handshake clears that bit.
  - o_last and o_none rules are unchanged.
- When undefined: port absent; lowest-first only, identical to the behaviour above.

Test Plan:
- Reset: hold rst_n = 0, then release -> o_valid 0, ld_ready 1, busy 0, cnt 0, o_idx 127 (WIDTH = 64).
- Load 64'h8000_0000_0000_0011 with o_ready = 1 -> o_idx 0, 4, 63 on three consecutive cycles starting the cycle after load. o_last only on the 63 beat; cnt = 3; then IDLE.
- Load 0 -> single beat o_none = 1, o_last = 1, o_idx = 127; cnt = 1; back to IDLE next cycle.
- Load 64'h6 with o_ready = 0 for 3 cycles -> o_idx stays 1, cnt 0. Then o_ready = 1 -> beats 1, 2.
- Load 64'hF0, accept beat 4, assert abort on the beat-5 cycle with o_ready = 1 and ld_valid = 1 -> next cycle o_valid 0, ld_ready 1, load refused. Separately, load 64'h1 then present 64'h2 on ld_vec with ld_valid during the last beat -> beats 0 then 1 with no gap.
- FLO_SCAN_MSB_EN defined: load 64'h11 with ld_msb = 1 -> beats 4, then 0, with o_last on 0.
